// File: rtl/parking_entry_gate.sv
// Entry-gate controller: debounces loop/pass sensors, admits a car by tag class
// against the occupancy counter's vacancy flags, drives the barrier and reports entries.
module parking_entry_gate #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TAG_TIMEOUT     = 32,
    parameter int OPEN_TIMEOUT    = 64,
    parameter int PULSE_CYCLES    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        loop_sensor,
    input  logic        pass_sensor,
    input  logic        tag_valid,
    input  logic        tag_is_uni,
    input  logic        uni_is_vacated_space,
    input  logic        free_is_vacated_space,
    output logic        barrier_open,
    output logic        car_entered,
    output logic        is_uni_car_entered,
    output logic        denied,
    output logic        timeout,
    output logic        busy,
    output logic [15:0] grant_count,
    output logic [15:0] deny_count
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (TAG_TIMEOUT > OPEN_TIMEOUT) ? TAG_TIMEOUT : OPEN_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int PLS_W   = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    localparam logic [DB_W-1:0]  DB_LIMIT    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [TMR_W-1:0] TAG_LAST    = TMR_W'(TAG_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] OPEN_LAST   = TMR_W'(OPEN_TIMEOUT - 1);
    localparam logic [PLS_W-1:0] PULSE_LAST  = PLS_W'(PULSE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WAIT_TAG = 4'd1,
        S_CHECK    = 4'd2,
        S_DENY     = 4'd3,
        S_OPEN     = 4'd4,
        S_PASSING  = 4'd5,
        S_REPORT   = 4'd6,
        S_HOLD     = 4'd7,
        S_ABORT    = 4'd8
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // index 0 = loop sensor, index 1 = pass sensor
    logic [1:0]            raw_s;
    logic [1:0]            deb_q, deb_d;
    logic [DB_W-1:0]       db_cnt_q [2];
    logic [DB_W-1:0]       db_cnt_d [2];
    logic                  loop_db_s, pass_db_s;

    state_t                state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [PLS_W-1:0]      pulse_q, pulse_d;
    logic                  cls_q, cls_d;
    logic                  vacancy_s;

    logic                  barrier_q, barrier_d;
    logic                  car_q, car_d;
    logic                  uni_q, uni_d;
    logic                  denied_q, denied_d;
    logic                  timeout_q, timeout_d;
    logic                  busy_q, busy_d;
    logic [15:0]           grant_q, grant_d;
    logic [15:0]           deny_q, deny_d;

    assign raw_s     = {pass_sensor, loop_sensor};
    assign loop_db_s = deb_q[0];
    assign pass_db_s = deb_q[1];

    // Debounce next state: the debounced level flips only after a run of disagreeing samples
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (raw_s[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LIMIT) begin
                    deb_d[i]    = raw_s[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    // Debounce registers
    always_ff @(posedge clock) begin
        if (reset) begin
            deb_q       <= 2'b00;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            deb_q       <= deb_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
        end
    end

    assign vacancy_s = cls_q ? uni_is_vacated_space : free_is_vacated_space;

    // Gate sequencing: next state, shared timer, pulse counter and latched class
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pulse_d = pulse_q;
        cls_d   = cls_q;
        case (state_q)
            S_IDLE: begin
                if (loop_db_s) begin
                    state_d = S_WAIT_TAG;
                    timer_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_TAG: begin
                // a tag arriving on the last allowed cycle still counts
                if (tag_valid) begin
                    cls_d   = tag_is_uni;
                    state_d = S_CHECK;
                end else if (!loop_db_s) begin
                    state_d = S_IDLE;
                end else if (timer_q == TAG_LAST) begin
                    state_d = S_DENY;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_CHECK: begin
                if (vacancy_s) begin
                    state_d = S_OPEN;
                    timer_d = '0;
                end else begin
                    state_d = S_DENY;
                end
            end
            S_DENY, S_ABORT: begin
                if (!loop_db_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            S_OPEN: begin
                if (pass_db_s) begin
                    state_d = S_PASSING;
                end else if (timer_q == OPEN_LAST) begin
                    state_d = S_ABORT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_PASSING: begin
                if (!pass_db_s) begin
                    state_d = S_REPORT;
                    pulse_d = '0;
                end else begin
                    state_d = S_PASSING;
                end
            end
            S_REPORT: begin
                if (pulse_q == PULSE_LAST) begin
                    state_d = S_HOLD;
                end else begin
                    pulse_d = pulse_q + PLS_W'(1);
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output next values decoded from the upcoming state so every output is a flop
    always_comb begin
        barrier_d = (state_d == S_OPEN) || (state_d == S_PASSING);
        car_d     = (state_d == S_REPORT);
        busy_d    = (state_d != S_IDLE);
        denied_d  = (state_d == S_DENY) && (state_q != S_DENY);
        timeout_d = ((state_q == S_WAIT_TAG) && (state_d == S_DENY)) ||
                    ((state_d == S_ABORT) && (state_q != S_ABORT));
        if ((state_d == S_REPORT) || (state_d == S_HOLD)) begin
            uni_d = cls_d;
        end else begin
            uni_d = 1'b0;
        end
        if ((state_d == S_REPORT) && (state_q != S_REPORT)) begin
            grant_d = sat_inc(grant_q);
        end else begin
            grant_d = grant_q;
        end
        if (denied_d || ((state_d == S_ABORT) && (state_q != S_ABORT))) begin
            deny_d = sat_inc(deny_q);
        end else begin
            deny_d = deny_q;
        end
    end

    // FSM state, timers and class register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            pulse_q <= '0;
            cls_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
            cls_q   <= cls_d;
        end
    end

    // Registered outputs and statistics
    always_ff @(posedge clock) begin
        if (reset) begin
            barrier_q <= 1'b0;
            car_q     <= 1'b0;
            uni_q     <= 1'b0;
            denied_q  <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            grant_q   <= 16'd0;
            deny_q    <= 16'd0;
        end else begin
            barrier_q <= barrier_d;
            car_q     <= car_d;
            uni_q     <= uni_d;
            denied_q  <= denied_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
            deny_q    <= deny_d;
        end
    end

    assign barrier_open       = barrier_q;
    assign car_entered        = car_q;
    assign is_uni_car_entered = uni_q;
    assign denied             = denied_q;
    assign timeout            = timeout_q;
    assign busy               = busy_q;
    assign grant_count        = grant_q;
    assign deny_count         = deny_q;

endmodule

// File: doc/parking_entry_gate.md
Name: parking_entry_gate

Overview:
- Entry-gate controller that sits directly upstream of the parking occupancy counter.
- Debounces the raw loop and pass sensors and reads the vehicle tag class (uni or free).
- Admits the car only if the occupancy counter reports a vacancy for that class, then drives the barrier.
- Emits the car_entered / is_uni_car_entered pair consumed by the counter, and keeps saturating grant and deny statistics.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a raw sensor must differ from its debounced value before the debounced value flips.
- TAG_TIMEOUT, 32, cycles allowed in WAIT_TAG before the car is denied.
- OPEN_TIMEOUT, 64, cycles allowed in OPEN for the pass sensor to assert before abort.
- PULSE_CYCLES, 2, width of the car_entered pulse in cycles (minimum 1).

Ports:
- clock  in  1  system clock; all logic rises on posedge.
- reset  in  1  synchronous, active-high.
- loop_sensor  in  1  raw; high while a car waits at the barrier.
- pass_sensor  in  1  raw; high while a car is under the barrier.
- tag_valid  in  1  one-cycle strobe; tag_is_uni is valid in the same cycle.
- tag_is_uni  in  1  1 = university permit, 0 = free car.
- uni_is_vacated_space  in  1  vacancy flag from the occupancy counter.
- free_is_vacated_space  in  1  vacancy flag from the occupancy counter.
- barrier_open  out  1  barrier actuator command.
- car_entered  out  1  entry pulse; the counter acts on its falling edge.
- is_uni_car_entered  out  1  class of the car being reported.
- denied  out  1  one-cycle pulse on refusal.
- timeout  out  1  one-cycle pulse on tag or pass timeout.
- busy  out  1  high in every state except IDLE.
- grant_count  out  16  saturating count of completed entries.
- deny_count  out  16  saturating count of denials and timeouts.

Behaviour:
- Reset: all outputs 0, state IDLE, debounced sensors 0, debounce counters and timers 0. Reset mid-transaction aborts immediately: barrier drops and no car_entered is generated.
- Debounce: each sensor has a counter that counts while raw != debounced and clears when they are equal. The debounced value flips when the counter reaches DEBOUNCE_CYCLES. Latency is DEBOUNCE_CYCLES+1 cycles from a stable raw change.
- IDLE: debounced loop high -> WAIT_TAG, timer cleared.
- WAIT_TAG:
  - tag_valid latches tag_is_uni into cls -> CHECK.
  - Debounced loop low first -> IDLE; no count change.
  - Timer reaches TAG_TIMEOUT -> DENY with timeout pulse.
  - tag_valid wins over a timeout in the same cycle.
- CHECK (1 cycle): the vacancy flag selected by cls is sampled this cycle. Flag = 1 -> OPEN, timer cleared; flag = 0 -> DENY.
- DENY:
  - denied pulses 1 cycle on entry; deny_count increments on entry.
  - Stays in DENY until debounced loop low -> IDLE. A further tag_valid while in DENY is ignored.
- OPEN:
  - barrier_open = 1.
  - Debounced pass high -> PASSING.
  - Timer reaches OPEN_TIMEOUT -> ABORT. ABORT pulses timeout, increments deny_count, drops the barrier, then waits for debounced loop low -> IDLE.
- PASSING:
  - barrier_open stays 1.
  - Debounced pass low -> REPORT; barrier_open drops in the same transition.
- REPORT:
  - car_entered = 1 for exactly PULSE_CYCLES cycles, with is_uni_car_entered = cls.
  - grant_count increments once, on entry to REPORT.
- HOLD (1 cycle): car_entered = 0 and is_uni_car_entered still = cls, so the class is stable across the falling edge. Then -> IDLE.
- is_uni_car_entered returns to 0 in IDLE.
- Counters saturate at 16'hFFFF.
- Sensor glitches shorter than DEBOUNCE_CYCLES have no effect.
- A vacancy flag change after CHECK does not revoke the grant; over-capacity is resolved downstream.

Test Plan:
- Uni car, uni flag = 1:
  - loop high, tag_valid with is_uni = 1, then pass high for 10 cycles, then low.
  - Required: barrier_open high from CHECK+1 until pass debounced low.
  - Required: car_entered high for 2 cycles, is_uni_car_entered = 1 through the cycle after the fall, grant_count = 1.
- Free car, free flag = 0: tag is_uni = 0 -> denied one pulse, barrier never opens, deny_count = 1, no car_entered. Loop low -> busy = 0 after debounce.
- Tag timeout: loop high, no tag for 32 cycles -> timeout and denied pulse, deny_count = 1, barrier stays 0.
- Pass timeout: granted, pass never asserts -> after 64 cycles in OPEN, timeout pulse, barrier drops, deny_count = 1, grant_count = 0.
- Glitch rejection: 3-cycle loop pulse in IDLE -> state stays IDLE. A 3-cycle pass dropout during PASSING -> single car_entered pulse only.
- Reset mid-OPEN: assert reset for 1 cycle -> next cycle barrier_open = 0, busy = 0, both counts = 0, no car_entered.
